// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 definitions: FSM encodings, fixed frame bit patterns
// and field widths. Used by both the responder and the management master.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST    = 3'd1,
        OP    = 3'd2,
        PHYAD = 3'd3,
        REGAD = 3'd4,
        TA    = 3'd5,
        DATA  = 3'd6
    } state_t;

    localparam logic [1:0] ST_BITS  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_BITS  = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

endpackage

// File: rtl/mdio_responder_if.sv
// Bundle of the MDIO pad signals and the local register port of the responder.
// The state field mirrors the responder FSM so checkers can bind to it.
interface mdio_responder_if;
    import mdio_pkg::*;

    logic                mdc;
    logic                mdio_in;
    logic                mdio_out;
    logic                mdio_oe;
    logic [REGAD_W-1:0]  reg_addr;
    logic [DATA_W-1:0]   reg_wdata;
    logic                reg_wr;
    logic                reg_rd;
    logic [DATA_W-1:0]   reg_rdata;
    logic                frame_err;
    state_t              state;

    // Register port handshake: reg_wr and reg_rd are single-clk strobes that
    // are never high together; reg_wdata/reg_addr are valid while reg_wr=1,
    // reg_addr is valid while reg_rd=1, and reg_rdata must be valid exactly
    // one clk after the reg_rd clk.
    modport slave (
        input  mdc, mdio_in, reg_rdata,
        output mdio_out, mdio_oe, reg_addr, reg_wdata, reg_wr, reg_rd,
               frame_err, state
    );

    modport master (
        output mdc, mdio_in, reg_rdata,
        input  mdio_out, mdio_oe, reg_addr, reg_wdata, reg_wr, reg_rd,
               frame_err, state
    );

endinterface

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a rising-edge detect
// taken between the second and a third flop.
module mdio_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    logic stage1;
    logic stage2;
    logic stage3;

    // Synchronizer chain; stage3 only serves the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
            stage3 <= 1'b0;
        end else begin
            stage1 <= din;
            stage2 <= stage1;
            stage3 <= stage2;
        end
    end

    assign dout = stage2;
    assign rise = stage2 & ~stage3;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause 22 MDIO responder. MDC/MDIO are oversampled on clk; every
// frame field is sampled on a synchronized MDC rising edge. Writes produce a
// reg_wr strobe, reads fetch reg_rdata and shift it out on MDIO.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'b00001,
    parameter int                 PRE_BITS = 32
) (
    input  logic             clk,
    input  logic             rst,
    mdio_responder_if.slave  bus
);

    localparam logic [5:0] PRE_MAX = 6'(PRE_BITS);

    logic mdc_rise;
    logic mdc_sync_unused;
    logic mdio_sync;
    logic mdio_rise_unused;
    logic bit_in;

    mdio_sync_edge u_mdc_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.mdc),
        .dout (mdc_sync_unused),
        .rise (mdc_rise)
    );

    mdio_sync_edge u_mdio_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.mdio_in),
        .dout (mdio_sync),
        .rise (mdio_rise_unused)
    );

    state_t              state_q, state_d;
    logic [5:0]          pre_q, pre_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [4:0]          fsh_q, fsh_d;
    logic                is_rd_q, is_rd_d;
    logic                match_q, match_d;
    logic [REGAD_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                out_q, out_d;
    logic                oe_q, oe_d;
    logic                wr_q, wr_d;
    logic                rd_stb_q, rd_stb_d;
    logic                err_q, err_d;
    logic                ld_q;

    logic [4:0]          field5;
    logic [1:0]          field2;

    // Our own drive on the line must never be read back as master data.
    assign bit_in = mdio_sync & ~oe_q;
    assign field5 = {fsh_q[3:0], bit_in};
    assign field2 = {fsh_q[0], bit_in};

    // State and datapath registers; strobes default low unless set this clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            fsh_q    <= '0;
            is_rd_q  <= 1'b0;
            match_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tx_q     <= '0;
            out_q    <= 1'b0;
            oe_q     <= 1'b0;
            wr_q     <= 1'b0;
            rd_stb_q <= 1'b0;
            err_q    <= 1'b0;
            ld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            fsh_q    <= fsh_d;
            is_rd_q  <= is_rd_d;
            match_q  <= match_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tx_q     <= tx_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            wr_q     <= wr_d;
            rd_stb_q <= rd_stb_d;
            err_q    <= err_d;
            ld_q     <= rd_stb_q;
        end
    end

    // Frame decoder: next state and datapath, advanced only on an MDC rise.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        fsh_d    = fsh_q;
        is_rd_d  = is_rd_q;
        match_d  = match_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tx_d     = tx_q;
        out_d    = out_q;
        oe_d     = oe_q;
        wr_d     = 1'b0;
        rd_stb_d = 1'b0;
        err_d    = 1'b0;

        // Read data arrives one clk after the reg_rd clk; no MDC rise can
        // coincide because MDC phases span several clks.
        if (ld_q) begin
            tx_d = bus.reg_rdata;
        end

        if (mdc_rise) begin
            fsh_d = field5;
            cnt_d = cnt_q + 5'd1;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (bit_in) begin
                        if (pre_q != PRE_MAX) pre_d = pre_q + 6'd1;
                    end else if (pre_q == PRE_MAX) begin
                        pre_d   = '0;
                        state_d = ST;
                    end else begin
                        pre_d = '0;
                    end
                end
                ST: begin
                    cnt_d = '0;
                    if (bit_in == ST_BITS[0]) begin
                        state_d = OP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                OP: begin
                    if (cnt_q == 5'd1) begin
                        cnt_d = '0;
                        if (field2 == OP_WRITE) begin
                            is_rd_d = 1'b0;
                            state_d = PHYAD;
                        end else if (field2 == OP_READ) begin
                            is_rd_d = 1'b1;
                            state_d = PHYAD;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                PHYAD: begin
                    if (cnt_q == 5'd4) begin
                        cnt_d   = '0;
                        match_d = (field5 == PHY_ADDR);
                        state_d = REGAD;
                    end
                end
                REGAD: begin
                    addr_d = {addr_q[3:0], bit_in};
                    if (cnt_q == 5'd4) begin
                        cnt_d    = '0;
                        rd_stb_d = is_rd_q & match_q;
                        state_d  = TA;
                    end
                end
                TA: begin
                    if (is_rd_q) begin
                        // First rise: take the line and drive the TA2 zero.
                        // Second rise: present D15.
                        if (cnt_q == 5'd0) begin
                            if (match_q) begin
                                oe_d  = 1'b1;
                                out_d = 1'b0;
                            end
                        end else begin
                            cnt_d   = '0;
                            state_d = DATA;
                            if (match_q) begin
                                out_d = tx_q[15];
                                tx_d  = {tx_q[14:0], 1'b0};
                            end
                        end
                    end else if (cnt_q == 5'd1) begin
                        cnt_d = '0;
                        if (field2 == TA_BITS) begin
                            state_d = DATA;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (is_rd_q) begin
                        if (cnt_q == 5'd15) begin
                            oe_d  = 1'b0;
                            out_d = 1'b0;
                        end else if (match_q) begin
                            out_d = tx_q[15];
                            tx_d  = {tx_q[14:0], 1'b0};
                        end
                    end else begin
                        wdata_d = {wdata_q[14:0], bit_in};
                        if (cnt_q == 5'd15) wr_d = match_q;
                    end
                    if (cnt_q == 5'd15) begin
                        cnt_d   = '0;
                        pre_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.mdio_out  = out_q;
    assign bus.mdio_oe   = oe_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_stb_q;
    assign bus.frame_err = err_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: acts as the MDIO master, models the
// local register file for reads, and checks strobes and MDIO read-back
// against expected queues.
module tb_mdio_responder;
    import mdio_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mdio_responder_if bus ();

    mdio_responder #(
        .PHY_ADDR (5'b00001),
        .PRE_BITS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [20:0] wr_exp_q[$];
    logic [4:0]  rd_exp_q[$];
    logic        err_exp_q[$];
    logic [1:0]  bit_exp_q[$];
    logic        oe_allowed = 1'b0;
    logic [15:0] rd_value = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One MDC period: data set up in the low phase, line sampled just before
    // the rising edge (what the responder drove on the previous rise).
    task automatic mdc_bit(input logic b, output logic s_oe, output logic s_out);
        bus.mdc     = 1'b0;
        bus.mdio_in = b;
        repeat (5) @(negedge clk);
        s_oe  = bus.mdio_oe;
        s_out = bus.mdio_out;
        bus.mdc = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic unused_oe, unused_out;
        for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], unused_oe, unused_out);
    endtask

    task automatic send_pre(input int n);
        logic unused_oe, unused_out;
        for (int i = 0; i < n; i++) mdc_bit(1'b1, unused_oe, unused_out);
    endtask

    task automatic idle_bit();
        logic unused_oe, unused_out;
        mdc_bit(1'b0, unused_oe, unused_out);
    endtask

    task automatic do_write(input int pre_n, input logic [4:0] phy, input logic [4:0] regad,
                            input logic [15:0] data, input logic [1:0] ta,
                            input logic exp_wr, input logic exp_err);
        if (exp_wr)  wr_exp_q.push_back({regad, data});
        if (exp_err) err_exp_q.push_back(1'b1);
        send_pre(pre_n);
        send_bits(32'(ST_BITS), 2);
        send_bits(32'(OP_WRITE), 2);
        send_bits(32'(phy), 5);
        send_bits(32'(regad), 5);
        send_bits(32'(ta), 2);
        send_bits(32'(data), 16);
        idle_bit();
        check("wr_pending", wr_exp_q.size(), 0);
        check("err_pending", err_exp_q.size(), 0);
        check("idle_after_wr", 32'(bus.state), 32'(IDLE));
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] regad,
                           input logic [15:0] data, input logic abort);
        logic       m;
        logic       s_oe, s_out;
        logic [1:0] e;
        int         last;
        m = (phy == 5'b00001);
        rd_value = data;
        if (m) rd_exp_q.push_back(regad);
        oe_allowed = m;
        for (int k = 1; k <= 18; k++) begin
            if (k == 1)      bit_exp_q.push_back(2'b00);
            else if (k == 2) bit_exp_q.push_back({m, 1'b0});
            else             bit_exp_q.push_back({m, m & data[18 - k]});
        end
        send_pre(32);
        send_bits(32'(ST_BITS), 2);
        send_bits(32'(OP_READ), 2);
        send_bits(32'(phy), 5);
        send_bits(32'(regad), 5);
        last = abort ? 7 : 18;
        for (int k = 1; k <= last; k++) begin
            mdc_bit(1'b1, s_oe, s_out);
            e = bit_exp_q.pop_front();
            check("rd_slot", 32'({s_oe, s_out}), 32'(e));
        end
        if (abort) begin
            bit_exp_q.delete();
            rst = 1'b1;
            @(negedge clk);
            check("abort_oe", 32'(bus.mdio_oe), 0);
            check("abort_out", 32'(bus.mdio_out), 0);
            check("abort_addr", 32'(bus.reg_addr), 0);
            check("abort_state", 32'(bus.state), 32'(IDLE));
            rst = 1'b0;
            oe_allowed = 1'b0;
            idle_bit();
        end else begin
            mdc_bit(1'b0, s_oe, s_out);
            check("rd_release", 32'({s_oe, s_out}), 0);
            oe_allowed = 1'b0;
        end
        check("rd_pending", rd_exp_q.size(), 0);
    endtask

    task automatic do_bad_op();
        err_exp_q.push_back(1'b1);
        send_pre(32);
        send_bits(32'(ST_BITS), 2);
        send_bits(32'h3, 2);
        idle_bit();
        check("err_pending_op", err_exp_q.size(), 0);
        check("idle_after_op_err", 32'(bus.state), 32'(IDLE));
    endtask

    // Scoreboard side: every strobe pops its expected entry.
    initial begin
        logic [20:0] we;
        logic [4:0]  re;
        logic        ee;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.reg_wr | bus.reg_rd) check("strobe_excl", 32'(bus.reg_wr & bus.reg_rd), 0);
                if (bus.reg_wr) begin
                    if (wr_exp_q.size() == 0) check("unexp_wr", 32'(bus.reg_wr), 0);
                    else begin
                        we = wr_exp_q.pop_front();
                        check("wr_addr", 32'(bus.reg_addr), 32'(we[20:16]));
                        check("wr_data", 32'(bus.reg_wdata), 32'(we[15:0]));
                    end
                end
                if (bus.reg_rd) begin
                    if (rd_exp_q.size() == 0) check("unexp_rd", 32'(bus.reg_rd), 0);
                    else begin
                        re = rd_exp_q.pop_front();
                        check("rd_addr", 32'(bus.reg_addr), 32'(re));
                    end
                end
                if (bus.frame_err) begin
                    if (err_exp_q.size() == 0) check("unexp_err", 32'(bus.frame_err), 0);
                    else ee = err_exp_q.pop_front();
                end
                if (bus.mdio_oe && !oe_allowed) check("oe_unexp", 32'(bus.mdio_oe), 0);
            end
        end
    end

    // Register file model: data valid only in the clk after the reg_rd clk.
    initial begin
        bus.reg_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (bus.reg_rd) begin
                @(negedge clk);
                bus.reg_rdata = rd_value;
                @(negedge clk);
                bus.reg_rdata = 16'hDEAD;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        bus.mdc     = 1'b0;
        bus.mdio_in = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_oe", 32'(bus.mdio_oe), 0);
        check("rst_out", 32'(bus.mdio_out), 0);
        check("rst_addr", 32'(bus.reg_addr), 0);
        check("rst_wdata", 32'(bus.reg_wdata), 0);
        check("rst_strobes", 32'({bus.reg_wr, bus.reg_rd, bus.frame_err}), 0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_write(32, 5'b00001, 5'd5, 16'hA5C3, TA_BITS, 1'b1, 1'b0);
        do_read(5'b00001, 5'd2, 16'h1234, 1'b0);

        do_write(32, 5'b00010, 5'd5, 16'h0F0F, TA_BITS, 1'b0, 1'b0);
        do_write(32, 5'b00001, 5'd9, 16'h5A5A, TA_BITS, 1'b1, 1'b0);

        do_write(31, 5'b00001, 5'd3, 16'h1357, TA_BITS, 1'b0, 1'b0);
        do_write(32, 5'b00001, 5'd3, 16'h1357, TA_BITS, 1'b1, 1'b0);

        do_bad_op();
        do_write(32, 5'b00001, 5'd4, 16'hA5C3, 2'b11, 1'b0, 1'b1);

        do_read(5'b00001, 5'd2, 16'h1234, 1'b1);
        do_read(5'b00001, 5'd7, 16'hBEEF, 1'b0);
        do_read(5'b00011, 5'd1, 16'hFFFF, 1'b0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
